fib_seq_ctrl: RTL and testbench
===============================

// Module: fib_seq_ctrl
// PURPOSE
//  Clocked sequencer for the self-timed Fibonacci datapath.
//  - Resets and starts the datapath, collects a requested number of terms, and forwards them downstream.
//  - Talks to the datapath over its 2-phase req/ack handshake and to the clocked side over valid/ready.
//  - Downstream backpressure stalls the datapath. A missing datapath response ends in a timeout error.
// PARAMETERS
//  DATA_WIDTH      16    width of datapath result bus and o_data
//  CNT_WIDTH       8     width of i_nterms / o_idx
//  RST_CYCLES      4     cycles o_fib_rst is held high at sequence start (>=1)
//  TIMEOUT_CYCLES  1024  max cycles waiting for a req transition before error (>=2)
// PORTS
//  clk         in   1           system clock
//  i_rst       in   1           reset, synchronous, active-high
//  i_start     in   1           start pulse; sampled only in IDLE
//  i_nterms    in   CNT_WIDTH   number of terms to collect; latched on accepted start
//  o_fib_rst   out  1           reset to datapath
//  o_fib_go    out  1           enable level to datapath
//  o_fib_ack   out  1           2-phase ack to datapath (toggles once per consumed term)
//  i_fib_req   in   1           2-phase req from datapath (asynchronous; bundled with data)
//  i_fib_data  in   DATA_WIDTH  datapath result, stable whenever req differs from ack
//  o_valid     out  1           o_data/o_idx hold a term
//  i_ready     in   1           downstream accepts term when o_valid & i_ready
//  o_data      out  DATA_WIDTH  captured term
//  o_idx       out  CNT_WIDTH   index of captured term, 0-based
//  o_busy      out  1           sequence in progress (any state except IDLE)
//  o_done      out  1           one-cycle pulse: all terms delivered
//  o_timeout   out  1           sticky error flag; cleared by next accepted start
// BEHAVIOUR
//  - Reset, evaluated at the clock edge: state=IDLE; all outputs, counters, sync flops and req_prev = 0.
//  - i_fib_req passes through 2-FF synchronizer -> req_s. New term detected when req_s != req_prev.
//  - IDLE:
//    - i_start & i_nterms!=0: latch n, idx=0, clear o_timeout -> RST.
//    - i_start & i_nterms==0: o_done pulses 1 cycle, stay IDLE, datapath untouched.
//  - RST:
//    - o_fib_rst=1 for exactly RST_CYCLES cycles; o_fib_ack forced 0.
//    - Then -> ARM.
//  - ARM (1 cycle): o_fib_rst=0, o_fib_go=1, req_prev<=req_s, timer=0 -> WAIT.
//  - WAIT:
//    - o_fib_go=1. On new term: o_data<=i_fib_data, o_idx<=idx, o_valid<=1, req_prev<=req_s -> OUT.
//    - Otherwise timer++. At timer==TIMEOUT_CYCLES-1 -> ERR.
//  - OUT:
//    - o_valid, o_data and o_idx are held stable until i_ready.
//    - On handshake (same edge): o_valid<=0, o_fib_ack toggles, timer=0.
//    - If idx==n-1 -> DONE, else idx++ -> WAIT.
//  - DONE: o_fib_go<=0, o_done=1 for 1 cycle -> IDLE.
//  - ERR: o_fib_go<=0, o_valid<=0, o_timeout<=1 -> IDLE. o_timeout stays set.
//  - Latency:
//    - req transition -> o_valid high: 3 cycles (2 sync + capture).
//    - Handshake -> ack toggle: registered in the same cycle as the handshake.
//  - i_start is ignored while o_busy. A req transition seen in OUT is not lost; it is detected on return to WAIT.
//  - i_rst mid-sequence: immediate return to reset values. No o_done, no o_timeout. Datapath restarted by the next start.
//  - idx compare is CNT_WIDTH wide, no wrap: n max is 2^CNT_WIDTH-1.
// STRUCTURE
//  - fib_ctrl_pkg: state_t enum {IDLE,RST,ARM,WAIT,OUT,DONE,ERR}, default width localparams.
//  - Sub-module: toggle_sync (2-FF synchronizer, 1 bit, reset to 0), instanced for i_fib_req.
//  - Rest (FSM, timer, idx counter, output register) stays flat in fib_seq_ctrl.
// TESTING
//  1. nterms=5, i_ready=1, model toggles req with 1,1,2,3,5:
//     - o_idx 0..4 with o_data 1,1,2,3,5.
//     - 5 ack toggles, one o_done pulse, o_fib_go low after.
//  2. nterms=4, i_ready low 10 cycles at idx 2:
//     - o_valid held, o_data=2 stable, no ack toggle until accept.
//     - Sequence then completes normally.
//  3. TIMEOUT_CYCLES=64, model never toggles:
//     - o_timeout=1 after 64 WAIT cycles, o_fib_go=0, o_busy=0.
//     - Next start clears o_timeout.
//  4. i_start with i_nterms=0: one o_done pulse, o_fib_rst never asserted, o_busy stays 0.
//  5. i_rst asserted at idx 3 of nterms=8:
//     - All outputs 0 after the edge.
//     - New start gives RST_CYCLES rst pulse and restarts at o_idx=0.
//  6. i_start pulsed during WAIT: ignored. n and idx unchanged, term count matches original nterms.

Source files
------------

// File: rtl/fib_ctrl_pkg.sv
// Shared types and default sizing for the Fibonacci datapath sequencer.
package fib_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    ARM,
    WAIT,
    OUT,
    DONE,
    ERR
  } state_t;

  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH      = 8;
  localparam int DEF_RST_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Bits needed for a counter that runs 0 .. count-1 (never narrower than 1).
  function automatic int cntBits(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchronizer for a single slowly-toggling level from the self-timed domain.
module toggle_sync (
  input  logic clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Clocked sequencer that restarts the self-timed Fibonacci datapath, collects
// the requested number of terms over 2-phase req/ack and hands them out on valid/ready.
module fib_seq_ctrl
  import fib_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [CNT_WIDTH-1:0]  i_nterms,
  output logic                  o_fib_rst,
  output logic                  o_fib_go,
  output logic                  o_fib_ack,
  input  logic                  i_fib_req,
  input  logic [DATA_WIDTH-1:0] i_fib_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout
);

  localparam int TIMER_W = cntBits(TIMEOUT_CYCLES);
  localparam int RCNT_W  = cntBits(RST_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RCNT_W-1:0]  RCNT_LAST  = RCNT_W'(RST_CYCLES - 1);

  state_t                r_state,    w_stateNext;
  logic [CNT_WIDTH-1:0]  r_n,        w_nNext;
  logic [CNT_WIDTH-1:0]  r_idx,      w_idxNext;
  logic [TIMER_W-1:0]    r_timer,    w_timerNext;
  logic [RCNT_W-1:0]     r_rstCnt,   w_rstCntNext;
  logic                  r_reqPrev,  w_reqPrevNext;
  logic                  r_fibRst,   w_fibRstNext;
  logic                  r_fibGo,    w_fibGoNext;
  logic                  r_fibAck,   w_fibAckNext;
  logic                  r_valid,    w_validNext;
  logic [DATA_WIDTH-1:0] r_data,     w_dataNext;
  logic [CNT_WIDTH-1:0]  r_outIdx,   w_outIdxNext;
  logic                  r_done,     w_doneNext;
  logic                  r_timeout,  w_timeoutNext;

  logic                  w_reqS;
  logic                  w_newTerm;
  logic [CNT_WIDTH-1:0]  w_lastIdx;

  toggle_sync u_reqSync (
    .clk   (clk),
    .i_rst (i_rst),
    .i_d   (i_fib_req),
    .o_q   (w_reqS)
  );

  // A term is pending whenever the synchronized req differs from the last one consumed.
  assign w_newTerm = (w_reqS != r_reqPrev);
  assign w_lastIdx = r_n - CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_idx     <= '0;
      r_timer   <= '0;
      r_rstCnt  <= '0;
      r_reqPrev <= 1'b0;
      r_fibRst  <= 1'b0;
      r_fibGo   <= 1'b0;
      r_fibAck  <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_outIdx  <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_n       <= w_nNext;
      r_idx     <= w_idxNext;
      r_timer   <= w_timerNext;
      r_rstCnt  <= w_rstCntNext;
      r_reqPrev <= w_reqPrevNext;
      r_fibRst  <= w_fibRstNext;
      r_fibGo   <= w_fibGoNext;
      r_fibAck  <= w_fibAckNext;
      r_valid   <= w_validNext;
      r_data    <= w_dataNext;
      r_outIdx  <= w_outIdxNext;
      r_done    <= w_doneNext;
      r_timeout <= w_timeoutNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_nNext       = r_n;
    w_idxNext     = r_idx;
    w_timerNext   = r_timer;
    w_rstCntNext  = r_rstCnt;
    w_reqPrevNext = r_reqPrev;
    w_fibRstNext  = r_fibRst;
    w_fibGoNext   = r_fibGo;
    w_fibAckNext  = r_fibAck;
    w_validNext   = r_valid;
    w_dataNext    = r_data;
    w_outIdxNext  = r_outIdx;
    w_doneNext    = 1'b0;
    w_timeoutNext = r_timeout;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_nterms != '0) begin
            w_nNext       = i_nterms;
            w_idxNext     = '0;
            w_timeoutNext = 1'b0;
            w_rstCntNext  = '0;
            w_fibRstNext  = 1'b1;
            w_fibAckNext  = 1'b0;
            w_stateNext   = RST;
          end else begin
            w_doneNext = 1'b1;
          end
        end
      end

      // o_fib_rst rises on entry, so it is high for exactly the RST_CYCLES spent here.
      RST: begin
        w_fibAckNext = 1'b0;
        if (r_rstCnt == RCNT_LAST) begin
          w_fibRstNext = 1'b0;
          w_fibGoNext  = 1'b1;
          w_stateNext  = ARM;
        end else begin
          w_rstCntNext = r_rstCnt + RCNT_W'(1);
        end
      end

      ARM: begin
        w_reqPrevNext = w_reqS;
        w_timerNext   = '0;
        w_stateNext   = WAIT;
      end

      WAIT: begin
        if (w_newTerm) begin
          w_dataNext    = i_fib_data;
          w_outIdxNext  = r_idx;
          w_validNext   = 1'b1;
          w_reqPrevNext = w_reqS;
          w_stateNext   = OUT;
        end else if (r_timer == TIMER_LAST) begin
          w_stateNext = ERR;
        end else begin
          w_timerNext = r_timer + TIMER_W'(1);
        end
      end

      // Holding the ack back while downstream stalls is what stalls the datapath.
      OUT: begin
        if (i_ready) begin
          w_validNext  = 1'b0;
          w_fibAckNext = ~r_fibAck;
          w_timerNext  = '0;
          if (r_idx == w_lastIdx) begin
            w_stateNext = DONE;
          end else begin
            w_idxNext   = r_idx + CNT_WIDTH'(1);
            w_stateNext = WAIT;
          end
        end
      end

      DONE: begin
        w_fibGoNext = 1'b0;
        w_doneNext  = 1'b1;
        w_stateNext = IDLE;
      end

      ERR: begin
        w_fibGoNext   = 1'b0;
        w_validNext   = 1'b0;
        w_timeoutNext = 1'b1;
        w_stateNext   = IDLE;
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign o_fib_rst = r_fibRst;
  assign o_fib_go  = r_fibGo;
  assign o_fib_ack = r_fibAck;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_idx     = r_outIdx;
  assign o_busy    = (r_state != IDLE);
  assign o_done    = r_done;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: a behavioural self-timed datapath drives req/data,
// and every delivered term is compared against Fibonacci values computed here.
module tb_fib_seq_ctrl;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int RC = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [CW-1:0] i_nterms;
  logic          o_fib_rst;
  logic          o_fib_go;
  logic          o_fib_ack;
  logic          dpReq;
  logic [DW-1:0] dpData;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_idx;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout;

  int checks = 0;
  int fails  = 0;

  // Datapath model and observers share one negedge process so their ordering is fixed.
  bit            dpEnable = 1'b1;
  logic [DW-1:0] dpA, dpB;
  int            dpDelay = 0;
  int            cyc = 0;
  int            lastToggleCyc = 0;
  int            latQ[$];
  int            ackToggles = 0;
  int            rstPulses = 0;
  int            rstRun = 0;
  int            lastRstPulse = 0;
  logic          prevAck = 1'b0;
  logic          prevValid = 1'b0;

  logic [DW-1:0] qData[$];
  logic [CW-1:0] qIdx[$];

  fib_seq_ctrl #(
    .DATA_WIDTH     (DW),
    .CNT_WIDTH      (CW),
    .RST_CYCLES     (RC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_nterms   (i_nterms),
    .o_fib_rst  (o_fib_rst),
    .o_fib_go   (o_fib_go),
    .o_fib_ack  (o_fib_ack),
    .i_fib_req  (dpReq),
    .i_fib_data (dpData),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_idx      (o_idx),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_timeout  (o_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    dpReq  = 1'b0;
    dpData = '0;
    dpA    = '0;
    dpB    = 16'd1;
  end

  always @(negedge clk) begin
    if (o_fib_rst) begin
      rstRun++;
    end else if (rstRun != 0) begin
      lastRstPulse = rstRun;
      rstPulses++;
      rstRun = 0;
    end
    if (o_fib_ack !== prevAck && !o_fib_rst) ackToggles++;
    prevAck = o_fib_ack;
    if (o_valid && !prevValid) latQ.push_back(cyc - lastToggleCyc);
    prevValid = o_valid;

    if (o_fib_rst) begin
      dpReq   = 1'b0;
      dpA     = '0;
      dpB     = 16'd1;
      dpDelay = $urandom_range(0, 4);
    end else if (o_fib_go && dpEnable && dpReq == o_fib_ack) begin
      if (dpDelay == 0) begin
        dpData        = dpB;
        {dpA, dpB}    = {dpB, dpA + dpB};
        dpReq         = ~dpReq;
        lastToggleCyc = cyc;
        dpDelay       = $urandom_range(0, 4);
      end else begin
        dpDelay--;
      end
    end
    cyc++;
  end

  function automatic logic [DW-1:0] fibRef(input int k);
    logic [DW-1:0] a, b, t;
    a = 1;
    b = 1;
    for (int j = 2; j <= k; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Starts one sequence and records every accepted term; returns at o_done or at a timeout error.
  task automatic collectSeq(input int n, input bit randReady, input int stallIdx, input int stallLen,
                            input int injectAt, output int doneCnt, output int busyCyc,
                            output int stallSeen, output bit holdBroken, output bit injected,
                            output bit timedOut);
    bit            prevHold;
    logic [DW-1:0] holdData;
    logic [CW-1:0] holdIdx;
    logic          holdAck;
    int            k;
    qData.delete();
    qIdx.delete();
    doneCnt = 0; busyCyc = 0; stallSeen = 0; holdBroken = 0; injected = 0; timedOut = 0;
    prevHold = 0; holdData = '0; holdIdx = '0; holdAck = 1'b0;
    @(negedge clk);
    i_nterms = CW'(n);
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (k = 0; k < 4000; k++) begin
      if (o_busy) busyCyc++;
      if (prevHold && (!o_valid || o_data !== holdData || o_idx !== holdIdx || o_fib_ack !== holdAck))
        holdBroken = 1;
      if (o_done) doneCnt++;
      if (o_done || (o_timeout && !o_busy)) break;
      if (injectAt >= 0 && !injected && qData.size() == injectAt && o_busy && o_fib_go && !o_valid) begin
        i_start  = 1'b1;
        i_nterms = CW'(2);
        injected = 1;
      end else begin
        i_start = 1'b0;
      end
      if (o_valid && o_idx == stallIdx && stallSeen < stallLen) begin
        i_ready = 1'b0;
        stallSeen++;
      end else begin
        i_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (o_valid && i_ready) begin
        qData.push_back(o_data);
        qIdx.push_back(o_idx);
      end
      prevHold = o_valid && !i_ready;
      holdData = o_data;
      holdIdx  = o_idx;
      holdAck  = o_fib_ack;
      @(negedge clk);
    end
    i_start = 1'b0;
    if (k >= 4000) timedOut = 1;
  endtask

  task automatic test_reset();
    logic [30:0] outs;
    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_nterms = '0;
    repeat (3) @(negedge clk);
    outs = {o_fib_rst, o_fib_go, o_fib_ack, o_valid, o_data, o_idx, o_busy, o_done, o_timeout};
    checks++;
    if (outs !== 31'd0) begin
      fails++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    outs = {o_fib_rst, o_fib_go, o_fib_ack, o_valid, o_data, o_idx, o_busy, o_done, o_timeout};
    checks++;
    if (outs !== 31'd0) begin
      fails++; $display("[TB] FAIL idle_after_reset: got %h expected 0", outs);
    end
  endtask

  task automatic test_basic();
    int t0, l0, p0, doneCnt, busyCyc, stallSeen;
    bit holdB, inj, tmo;
    t0 = ackToggles; l0 = latQ.size(); p0 = rstPulses;
    collectSeq(5, 0, -1, 0, -1, doneCnt, busyCyc, stallSeen, holdB, inj, tmo);
    checks++;
    if (tmo) begin fails++; $display("[TB] FAIL basic_timeout: got budget expired expected completion"); end
    checks++;
    if (qData.size() != 5) begin fails++; $display("[TB] FAIL basic_count: got %0d expected 5", qData.size()); end
    for (int i = 0; i < qData.size() && i < 5; i++) begin
      checks++;
      if (qData[i] !== fibRef(i) || qIdx[i] !== CW'(i)) begin
        fails++; $display("[TB] FAIL basic_term%0d: got data %0d idx %0d expected data %0d idx %0d",
                          i, qData[i], qIdx[i], fibRef(i), i);
      end
    end
    checks++;
    if (ackToggles - t0 != 5) begin fails++; $display("[TB] FAIL basic_acks: got %0d expected 5", ackToggles - t0); end
    checks++;
    if (doneCnt != 1) begin fails++; $display("[TB] FAIL basic_done: got %0d expected 1", doneCnt); end
    checks++;
    if (o_fib_go !== 1'b0) begin fails++; $display("[TB] FAIL basic_go_low: got %b expected 0", o_fib_go); end
    checks++;
    if (rstPulses - p0 != 1 || lastRstPulse != RC) begin
      fails++; $display("[TB] FAIL basic_rst_pulse: got %0d pulses of %0d expected 1 of %0d",
                        rstPulses - p0, lastRstPulse, RC);
    end
    checks++;
    if (latQ.size() - l0 != 5) begin fails++; $display("[TB] FAIL basic_valid_rises: got %0d expected 5", latQ.size() - l0); end
    for (int i = l0; i < latQ.size(); i++) begin
      checks++;
      if (latQ[i] != 3) begin fails++; $display("[TB] FAIL basic_latency%0d: got %0d expected 3", i - l0, latQ[i]); end
    end
  endtask

  task automatic test_backpressure();
    int t0, doneCnt, busyCyc, stallSeen;
    bit holdB, inj, tmo;
    t0 = ackToggles;
    collectSeq(4, 0, 2, 10, -1, doneCnt, busyCyc, stallSeen, holdB, inj, tmo);
    checks++;
    if (stallSeen != 10) begin fails++; $display("[TB] FAIL bp_stall_len: got %0d expected 10", stallSeen); end
    checks++;
    if (holdB) begin fails++; $display("[TB] FAIL bp_hold: got output change during stall expected stable"); end
    checks++;
    if (qData.size() != 4) begin fails++; $display("[TB] FAIL bp_count: got %0d expected 4", qData.size()); end
    for (int i = 0; i < qData.size() && i < 4; i++) begin
      checks++;
      if (qData[i] !== fibRef(i) || qIdx[i] !== CW'(i)) begin
        fails++; $display("[TB] FAIL bp_term%0d: got data %0d idx %0d expected data %0d idx %0d",
                          i, qData[i], qIdx[i], fibRef(i), i);
      end
    end
    checks++;
    if (doneCnt != 1 || tmo || ackToggles - t0 != 4) begin
      fails++; $display("[TB] FAIL bp_finish: got done %0d acks %0d expected done 1 acks 4", doneCnt, ackToggles - t0);
    end
  endtask

  task automatic test_timeout();
    int doneCnt, busyCyc, stallSeen;
    bit holdB, inj, tmo;
    dpEnable = 1'b0;
    collectSeq(3, 0, -1, 0, -1, doneCnt, busyCyc, stallSeen, holdB, inj, tmo);
    checks++;
    if (tmo || o_timeout !== 1'b1) begin fails++; $display("[TB] FAIL to_flag: got %b expected 1", o_timeout); end
    checks++;
    if (o_fib_go !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("[TB] FAIL to_idle: got go %b busy %b expected 0 0", o_fib_go, o_busy);
    end
    checks++;
    if (busyCyc != RC + 1 + TO + 1) begin
      fails++; $display("[TB] FAIL to_duration: got %0d busy cycles expected %0d", busyCyc, RC + 1 + TO + 1);
    end
    checks++;
    if (qData.size() != 0 || doneCnt != 0) begin
      fails++; $display("[TB] FAIL to_no_terms: got %0d terms %0d done expected 0 0", qData.size(), doneCnt);
    end
    dpEnable = 1'b1;
    collectSeq(2, 0, -1, 0, -1, doneCnt, busyCyc, stallSeen, holdB, inj, tmo);
    checks++;
    if (o_timeout !== 1'b0) begin fails++; $display("[TB] FAIL to_clear: got %b expected 0", o_timeout); end
    checks++;
    if (qData.size() != 2 || doneCnt != 1 || tmo) begin
      fails++; $display("[TB] FAIL to_recover: got %0d terms %0d done expected 2 1", qData.size(), doneCnt);
    end
  endtask

  task automatic test_zero_terms();
    int doneCnt, busySeen, rstSeen, p0;
    logic firstDone;
    p0 = rstPulses; doneCnt = 0; busySeen = 0; rstSeen = 0;
    @(negedge clk);
    i_nterms = '0;
    i_start  = 1'b1;
    @(negedge clk);
    i_start   = 1'b0;
    firstDone = o_done;
    for (int i = 0; i < 8; i++) begin
      if (o_done) doneCnt++;
      if (o_busy) busySeen++;
      if (o_fib_rst) rstSeen++;
      @(negedge clk);
    end
    checks++;
    if (firstDone !== 1'b1 || doneCnt != 1) begin
      fails++; $display("[TB] FAIL zero_done: got first %b count %0d expected 1 1", firstDone, doneCnt);
    end
    checks++;
    if (busySeen != 0) begin fails++; $display("[TB] FAIL zero_busy: got %0d busy cycles expected 0", busySeen); end
    checks++;
    if (rstSeen != 0 || rstPulses != p0) begin
      fails++; $display("[TB] FAIL zero_rst: got %0d rst cycles expected 0", rstSeen);
    end
  endtask

  task automatic test_mid_reset();
    logic [30:0] outs;
    int doneCnt, busyCyc, stallSeen, found;
    bit holdB, inj, tmo;
    found = 0;
    @(negedge clk);
    i_nterms = CW'(8);
    i_start  = 1'b1;
    i_ready  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (o_valid && o_idx == CW'(3)) begin
        found   = 1;
        i_rst   = 1'b1;
        i_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (found == 0) begin fails++; $display("[TB] FAIL mr_reach_idx3: got budget expired expected idx 3"); end
    @(negedge clk);
    outs = {o_fib_rst, o_fib_go, o_fib_ack, o_valid, o_data, o_idx, o_busy, o_done, o_timeout};
    checks++;
    if (outs !== 31'd0) begin fails++; $display("[TB] FAIL mr_outputs: got %h expected 0", outs); end
    i_rst = 1'b0;
    collectSeq(3, 0, -1, 0, -1, doneCnt, busyCyc, stallSeen, holdB, inj, tmo);
    checks++;
    if (lastRstPulse != RC) begin fails++; $display("[TB] FAIL mr_rst_pulse: got %0d expected %0d", lastRstPulse, RC); end
    checks++;
    if (qData.size() != 3 || doneCnt != 1 || tmo) begin
      fails++; $display("[TB] FAIL mr_restart: got %0d terms %0d done expected 3 1", qData.size(), doneCnt);
    end
    for (int i = 0; i < qData.size() && i < 3; i++) begin
      checks++;
      if (qData[i] !== fibRef(i) || qIdx[i] !== CW'(i)) begin
        fails++; $display("[TB] FAIL mr_term%0d: got data %0d idx %0d expected data %0d idx %0d",
                          i, qData[i], qIdx[i], fibRef(i), i);
      end
    end
  endtask

  task automatic test_start_ignored();
    int doneCnt, busyCyc, stallSeen;
    bit holdB, inj, tmo;
    collectSeq(6, 1, -1, 0, 2, doneCnt, busyCyc, stallSeen, holdB, inj, tmo);
    checks++;
    if (!inj) begin fails++; $display("[TB] FAIL si_injected: got no start pulse in WAIT expected one"); end
    checks++;
    if (qData.size() != 6 || doneCnt != 1 || tmo) begin
      fails++; $display("[TB] FAIL si_count: got %0d terms %0d done expected 6 1", qData.size(), doneCnt);
    end
    for (int i = 0; i < qData.size() && i < 6; i++) begin
      checks++;
      if (qData[i] !== fibRef(i) || qIdx[i] !== CW'(i)) begin
        fails++; $display("[TB] FAIL si_term%0d: got data %0d idx %0d expected data %0d idx %0d",
                          i, qData[i], qIdx[i], fibRef(i), i);
      end
    end
  endtask

  task automatic test_random();
    int n, doneCnt, busyCyc, stallSeen;
    bit holdB, inj, tmo;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 12);
      collectSeq(n, 1, -1, 0, -1, doneCnt, busyCyc, stallSeen, holdB, inj, tmo);
      checks++;
      if (qData.size() != n || doneCnt != 1 || tmo || holdB) begin
        fails++; $display("[TB] FAIL rnd%0d_run: got %0d terms done %0d hold_broken %b expected %0d terms done 1",
                          r, qData.size(), doneCnt, holdB, n);
      end
      for (int i = 0; i < qData.size() && i < n; i++) begin
        checks++;
        if (qData[i] !== fibRef(i) || qIdx[i] !== CW'(i)) begin
          fails++; $display("[TB] FAIL rnd%0d_term%0d: got data %0d idx %0d expected data %0d idx %0d",
                            r, i, qData[i], qIdx[i], fibRef(i), i);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] starting fib_seq_ctrl bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero_terms();
    test_mid_reset();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
